multicycle_mainfsm: RTL and testbench

Multicycle ARM control unit. It decodes the instruction fields (Op, Funct, Rd), sequences the fetch/decode/execute/writeback steps, and drives the datapath mux selects. It also produces the unconditional write requests (RegW, MemW, Branch, PCS, FlagW) that the conditional-execution logic gates with CondEx. The block sits between the instruction register and the condition-gating stage in the controller.

---
 rtl/multicycle_mainfsm.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_mainfsm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_mainfsm.sv
// Multicycle ARM main controller: sequences fetch/decode/execute/writeback and decodes datapath controls.
// Optional macro CMP_NOWB_EN: CMP returns from execute straight to FETCH, skipping ALUWB.
module multicycle_mainfsm #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic [1:0] ALUControl,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       PCS,
  output logic [1:0] FlagW
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(4'd0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(4'd1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(4'd2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(4'd3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4'd4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(4'd5);
  localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(4'd6);
  localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(4'd7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(4'd8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(4'd9);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic [1:0] alu_ctl_s;
  logic       cmd_known_s;
  logic       cmd_arith_s;
  logic       is_cmp_s;
  logic [1:0] flagw_dp_s;
  logic       wb_en_s;
  logic       reg_w_s;
  logic       branch_s;

  // State register, cleared to FETCH while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Data-processing command decode; unknown commands behave as ADD without side effects.
  always_comb begin
    alu_ctl_s   = ALU_ADD;
    cmd_known_s = 1'b0;
    cmd_arith_s = 1'b0;
    is_cmp_s    = 1'b0;
    case (Funct[4:1])
      CMD_ADD: begin alu_ctl_s = ALU_ADD; cmd_known_s = 1'b1; cmd_arith_s = 1'b1; end
      CMD_SUB: begin alu_ctl_s = ALU_SUB; cmd_known_s = 1'b1; cmd_arith_s = 1'b1; end
      CMD_AND: begin alu_ctl_s = ALU_AND; cmd_known_s = 1'b1; end
      CMD_ORR: begin alu_ctl_s = ALU_ORR; cmd_known_s = 1'b1; end
      CMD_CMP: begin
        alu_ctl_s   = ALU_SUB;
        cmd_known_s = 1'b1;
        cmd_arith_s = 1'b1;
        is_cmp_s    = 1'b1;
      end
      default: begin
        alu_ctl_s   = ALU_ADD;
        cmd_known_s = 1'b0;
      end
    endcase
    if (cmd_known_s) begin
      flagw_dp_s = {Funct[0], Funct[0] & cmd_arith_s};
    end else begin
      flagw_dp_s = 2'b00;
    end
    wb_en_s = cmd_known_s & ~is_cmp_s;
  end

  // Next-state selection.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI: begin
`ifdef CMP_NOWB_EN
        if (is_cmp_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
`else
        state_d = S_ALUWB;
`endif
      end
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode.
  always_comb begin
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    NextPC     = 1'b0;
    ALUControl = ALU_ADD;
    reg_w_s    = 1'b0;
    MemW       = 1'b0;
    branch_s   = 1'b0;
    FlagW      = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_s   = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: begin
        ALUControl = alu_ctl_s;
        FlagW      = flagw_dp_s;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctl_s;
        FlagW      = flagw_dp_s;
      end
      S_ALUWB: reg_w_s = wb_en_s;
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch_s  = 1'b1;
      end
      default: IRWrite = 1'b0;
    endcase
  end

  assign RegW   = reg_w_s;
  assign Branch = branch_s;
  // A register write to R15 redirects the PC just like a branch.
  assign PCS    = ((Rd == 4'd15) & reg_w_s) | branch_s;

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Randomized bench for multicycle_mainfsm against an instruction-level step model.
module tb_multicycle_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, PCS;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW;

  int checks;
  int failures;

  multicycle_mainfsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .ALUControl(ALUControl),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .PCS(PCS), .FlagW(FlagW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step kinds of an instruction, in the order the spec's instruction flow names them.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
  localparam int P_MEMWRITE = 5, P_EXER = 6, P_EXEI = 7, P_ALUWB = 8, P_BRANCH = 9;

  function automatic logic [16:0] dut_vec();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, ALUControl,
            RegW, MemW, Branch, PCS, FlagW};
  endfunction

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // Semantics of the data-processing command: ALU op, known-ness, arithmetic flag class.
  function automatic void dp_info(input logic [5:0] f, output logic [1:0] alu,
                                  output bit known, output bit arith, output bit cmp);
    logic [3:0] c;
    c = f[4:1];
    known = 1; arith = 0; cmp = 0; alu = 2'b00;
    if (c == 4'b0100) begin alu = 2'b00; arith = 1; end
    else if (c == 4'b0010) begin alu = 2'b01; arith = 1; end
    else if (c == 4'b0000) alu = 2'b10;
    else if (c == 4'b1100) alu = 2'b11;
    else if (c == 4'b1010) begin alu = 2'b01; arith = 1; cmp = 1; end
    else known = 0;
  endfunction

  function automatic logic [16:0] exp_vec(input int ph, input logic [5:0] f, input logic [3:0] rd);
    logic irw, adr, npc, rw, mw, br;
    logic [1:0] sa, sb, rs, alu, fw, dalu;
    bit known, arith, cmp;
    irw = 0; adr = 0; npc = 0; rw = 0; mw = 0; br = 0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00; alu = 2'b00; fw = 2'b00;
    dp_info(f, dalu, known, arith, cmp);
    if (ph == P_FETCH) begin irw = 1; npc = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
    else if (ph == P_DECODE) begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
    else if (ph == P_MEMADR) sb = 2'b01;
    else if (ph == P_MEMREAD) adr = 1;
    else if (ph == P_MEMWB) begin rs = 2'b01; rw = 1; end
    else if (ph == P_MEMWRITE) begin adr = 1; mw = 1; end
    else if (ph == P_EXER || ph == P_EXEI) begin
      if (ph == P_EXEI) sb = 2'b01;
      alu = dalu;
      fw = known ? {f[0], f[0] & arith} : 2'b00;
    end
    else if (ph == P_ALUWB) rw = known && !cmp;
    else if (ph == P_BRANCH) begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1; end
    return {irw, adr, sa, sb, rs, npc, alu, rw, mw, br, (rw && rd == 4'd15) || br, fw};
  endfunction

  function automatic void build_steps(input logic [1:0] op, input logic [5:0] f, ref int q[$]);
    logic [1:0] a; bit k, ar, cmp;
    q.delete();
    q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    dp_info(f, a, k, ar, cmp);
    case (op)
      2'b01: begin
        q.push_back(P_MEMADR);
        if (f[0]) begin q.push_back(P_MEMREAD); q.push_back(P_MEMWB); end
        else q.push_back(P_MEMWRITE);
      end
      2'b00: begin
        q.push_back(f[5] ? P_EXEI : P_EXER);
`ifdef CMP_NOWB_EN
        if (!cmp) q.push_back(P_ALUWB);
`else
        q.push_back(P_ALUWB);
`endif
      end
      2'b10: q.push_back(P_BRANCH);
      default: q.push_back(P_FETCH);
    endcase
    if (op == 2'b11) void'(q.pop_back());
  endfunction

  // Runs one instruction from FETCH; abort_at>=0 asserts reset after that many steps.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input int abort_at);
    int q[$];
    build_steps(op, f, q);
    Op = op; Funct = f; Rd = rd;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      else #1;
      check_eq($sformatf("%s step%0d", name, i), dut_vec(), exp_vec(q[i], f, rd));
      if (abort_at == i) begin
        reset = 1'b0;
        #1;
        check_eq($sformatf("%s abort", name), dut_vec(), exp_vec(P_FETCH, f, rd));
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq($sformatf("%s release", name), dut_vec(), exp_vec(P_FETCH, f, rd));
        return;
      end
    end
    @(posedge clk); #2;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    #1;
    check_eq("reset held", dut_vec(), exp_vec(P_FETCH, Funct, Rd));
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("reset release", dut_vec(), exp_vec(P_FETCH, Funct, Rd));

    run_instr("LDR", 2'b01, 6'b011001, 4'd3, -1);
    run_instr("STR", 2'b01, 6'b011000, 4'd5, -1);
    run_instr("ADDS_I", 2'b00, 6'b101001, 4'd15, -1);
    run_instr("B", 2'b10, 6'b000000, 4'd0, -1);
    run_instr("UNDEF", 2'b11, 6'b111111, 4'd15, -1);
    run_instr("CMP_R", 2'b00, 6'b010101, 4'd15, -1);
    run_instr("LDR_PC", 2'b01, 6'b000001, 4'd15, 2);
    run_instr("ORR", 2'b00, 6'b011000, 4'd15, -1);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] op; logic [5:0] f; logic [3:0] rd; int ab;
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 4))
          0: f[4:1] = 4'b0100;
          1: f[4:1] = 4'b0010;
          2: f[4:1] = 4'b0000;
          3: f[4:1] = 4'b1100;
          default: f[4:1] = 4'b1010;
        endcase
      end
      rd = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_instr($sformatf("rnd%0d", n), op, f, rd, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
